// File: rtl/toy_bpu_ras_rcnt.sv
// toy_bpu_ras_rcnt: return-address stack with per-entry repeat counters, kept as a
// speculative copy (predict side) and a committed copy (backend) that restores it on flush.
module toy_bpu_ras_rcnt_next #(
    parameter int AW    = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 3,
    parameter int PW    = 4
) (
    input  logic                       en,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              ra,
    input  logic [DEPTH-1:0][AW-1:0]   addr,
    input  logic [DEPTH-1:0][CW-1:0]   cnt,
    input  logic [PW:0]                top,
    input  logic [PW:0]                btm,
    output logic [DEPTH-1:0][AW-1:0]   addr_n,
    output logic [DEPTH-1:0][CW-1:0]   cnt_n,
    output logic [PW:0]                top_n,
    output logic [PW:0]                btm_n
);
    logic [PW-1:0] ti;
    logic [PW-1:0] pi;
    logic          full;

    assign ti = top[PW-1:0] - PW'(1);

    // Pop is applied first so a call+ret pushes onto the post-pop stack.
    always_comb begin
        addr_n = addr;
        cnt_n  = cnt;
        top_n  = top;
        btm_n  = btm;
        if (en && ret && top != btm) begin
            if (cnt[ti] != '0) cnt_n[ti] = cnt[ti] - CW'(1);
            else top_n = top - (PW+1)'(1);
        end
        pi   = top_n[PW-1:0] - PW'(1);
        full = top_n[PW-1:0] == btm[PW-1:0] && top_n[PW] != btm[PW];
        if (en && call) begin
            if (top_n != btm && ra == addr[pi] && cnt_n[pi] != '1) cnt_n[pi] = cnt_n[pi] + CW'(1);
            else begin
                addr_n[top_n[PW-1:0]] = ra;
                cnt_n[top_n[PW-1:0]]  = '0;
                btm_n = full ? btm + (PW+1)'(1) : btm;
                top_n = top_n + (PW+1)'(1);
            end
        end
    end
endmodule

module toy_bpu_ras_rcnt #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 16,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_vld,
    input  logic                  pred_call,
    input  logic                  pred_ret,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  pred_is_cext,
    output logic                  top_vld,
    output logic [ADDR_WIDTH-1:0] top_pc,
    input  logic                  cmt_vld,
    input  logic                  cmt_call,
    input  logic                  cmt_ret,
    input  logic [ADDR_WIDTH-1:0] cmt_pc,
    input  logic                  cmt_is_cext,
    input  logic                  flush,
    output logic [15:0]           ovf_cnt
);
    localparam int RAS_PTR_WIDTH = $clog2(RAS_DEPTH);

    logic [RAS_DEPTH-1:0][ADDR_WIDTH-1:0] s_addr, s_addr_n, c_addr, c_addr_n;
    logic [RAS_DEPTH-1:0][CNT_WIDTH-1:0]  s_cnt, s_cnt_n, c_cnt, c_cnt_n;
    logic [RAS_PTR_WIDTH:0]               s_top, s_top_n, s_btm, s_btm_n;
    logic [RAS_PTR_WIDTH:0]               c_top, c_top_n, c_btm, c_btm_n;
    logic [ADDR_WIDTH-1:0]                pred_ra, cmt_ra;
    logic                                 s_en;

    assign pred_ra = pred_pc + (pred_is_cext ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
    assign cmt_ra  = cmt_pc + (cmt_is_cext ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
    assign s_en    = pred_vld && !flush;

    toy_bpu_ras_rcnt_next #(
        .AW(ADDR_WIDTH), .DEPTH(RAS_DEPTH), .CW(CNT_WIDTH), .PW(RAS_PTR_WIDTH)
    ) u_spec (
        .en(s_en), .call(pred_call), .ret(pred_ret), .ra(pred_ra),
        .addr(s_addr), .cnt(s_cnt), .top(s_top), .btm(s_btm),
        .addr_n(s_addr_n), .cnt_n(s_cnt_n), .top_n(s_top_n), .btm_n(s_btm_n)
    );

    toy_bpu_ras_rcnt_next #(
        .AW(ADDR_WIDTH), .DEPTH(RAS_DEPTH), .CW(CNT_WIDTH), .PW(RAS_PTR_WIDTH)
    ) u_cmt (
        .en(cmt_vld), .call(cmt_call), .ret(cmt_ret), .ra(cmt_ra),
        .addr(c_addr), .cnt(c_cnt), .top(c_top), .btm(c_btm),
        .addr_n(c_addr_n), .cnt_n(c_cnt_n), .top_n(c_top_n), .btm_n(c_btm_n)
    );

    // btm only advances when the oldest entry is dropped, so its movement is the overflow event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_top   <= '0;
            s_btm   <= '0;
            c_top   <= '0;
            c_btm   <= '0;
            ovf_cnt <= '0;
        end else begin
            c_top <= c_top_n;
            c_btm <= c_btm_n;
            s_top <= flush ? c_top_n : s_top_n;
            s_btm <= flush ? c_btm_n : s_btm_n;
            if (s_en && s_btm_n != s_btm && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        c_addr <= c_addr_n;
        c_cnt  <= c_cnt_n;
        s_addr <= flush ? c_addr_n : s_addr_n;
        s_cnt  <= flush ? c_cnt_n : s_cnt_n;
    end

    assign top_vld = s_top != s_btm;
    assign top_pc  = top_vld ? s_addr[s_top[RAS_PTR_WIDTH-1:0] - RAS_PTR_WIDTH'(1)] : '0;
endmodule
